// File: rtl/bht_gshare.sv
// Gshare branch history table: saturating counters with a sequential reset-time clear.
// Define BHT_GSHARE_EN to enable the speculative global history register and its repair path.
module bht_gshare #(
  parameter int ENTRIES = 256,
  parameter int IDX_W   = 8,
  parameter int CTR_W   = 2,
  parameter int HIST_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              pred_valid,
  input  logic [IDX_W-1:0]  pred_idx,
  output logic              pred_ready,
  output logic              pred_resp_valid,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic              upd_mispred
);

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'((1 << CTR_W) - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   clrPtr_q;
  logic               ready_q;
  logic               respValid_q;
  logic               taken_q;
  logic [CTR_W-1:0]   ctrTable_q [ENTRIES];

  logic [IDX_W-1:0]   ridx;
  logic [IDX_W-1:0]   widx;
  logic [CTR_W-1:0]   rdCtr;
  logic               rdTaken;
  logic [CTR_W-1:0]   wrCtr;
  logic [CTR_W-1:0]   updCtr_d;

  assign rdCtr   = ctrTable_q[ridx];
  assign rdTaken = rdCtr[CTR_W-1];
  assign wrCtr   = ctrTable_q[widx];

  always_comb begin
    updCtr_d = wrCtr;
    if (upd_taken && (wrCtr != CTR_MAX)) begin
      updCtr_d = wrCtr + CTR_W'(1);
    end else if (!upd_taken && (wrCtr != '0)) begin
      updCtr_d = wrCtr - CTR_W'(1);
    end
  end

  // Control FSM: INIT walks clrPtr over every entry once, then READY forever.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clrPtr_q    <= '0;
      ready_q     <= 1'b0;
      respValid_q <= 1'b0;
      taken_q     <= 1'b0;
    end else if (rdy) begin
      case (state_q)
        ST_INIT: begin
          clrPtr_q <= clrPtr_q + IDX_W'(1);
          if (clrPtr_q == LAST_IDX) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          respValid_q <= pred_valid;
          if (pred_valid) begin
            taken_q <= rdTaken;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Single write port, shared by the clear sweep and commit-time training.
  always_ff @(posedge clk) begin
    if (rst_n && rdy) begin
      if (state_q == ST_INIT) begin
        ctrTable_q[clrPtr_q] <= CTR_WNT;
      end else if (upd_valid) begin
        ctrTable_q[widx] <= updCtr_d;
      end
    end
  end

`ifdef BHT_GSHARE_EN
  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_d;
  logic [HIST_W-1:0] hist_q;
  logic [HIST_W:0]   specShift;
  logic [HIST_W:0]   repairShift;

  // A mispredict repair overrides the speculative shift in the same cycle.
  always_comb begin
    specShift   = {ghr_q, rdTaken};
    repairShift = {upd_hist, upd_taken};
    ghr_d       = ghr_q;
    if (pred_valid) begin
      ghr_d = specShift[HIST_W-1:0];
    end
    if (upd_valid && upd_mispred) begin
      ghr_d = repairShift[HIST_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q  <= '0;
      hist_q <= '0;
    end else if (rdy && (state_q == ST_READY)) begin
      ghr_q <= ghr_d;
      if (pred_valid) begin
        hist_q <= ghr_q;
      end
    end
  end

  assign ridx      = pred_idx ^ IDX_W'(ghr_q);
  assign widx      = upd_idx ^ IDX_W'(upd_hist);
  assign pred_hist = hist_q;
`else
  logic unused_hist;

  assign unused_hist = ^{upd_hist, upd_mispred};
  assign ridx        = pred_idx;
  assign widx        = upd_idx;
  assign pred_hist   = '0;
`endif

  assign pred_ready      = ready_q;
  assign pred_resp_valid = respValid_q;
  assign pred_taken      = taken_q;

endmodule

// File: tb/tb_bht_gshare.sv
// Self-checking bench for bht_gshare against a table/history model; honours BHT_GSHARE_EN.
// A second small instance (CTR_W=3) covers the wider-counter init value.
module tb_bht_gshare;

  logic       clk;
  logic       rst_n;
  logic       rdy;
  logic       pred_valid;
  logic [7:0] pred_idx;
  logic       pred_ready;
  logic       pred_resp_valid;
  logic       pred_taken;
  logic [7:0] pred_hist;
  logic       upd_valid;
  logic [7:0] upd_idx;
  logic [7:0] upd_hist;
  logic       upd_taken;
  logic       upd_mispred;

  logic       sPredValid;
  logic [3:0] sPredIdx;
  logic       sPredReady;
  logic       sRespValid;
  logic       sTaken;
  logic [3:0] sHist;
  logic       sUpdValid;
  logic [3:0] sUpdIdx;
  logic       sUpdTaken;

  int checks = 0;
  int failures = 0;

`ifdef BHT_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  // Reference state: counter values as plain integers, history as an integer.
  int mctr [256];
  int mghr;
  int expValid;
  int expTaken;
  int expHist;

  bht_gshare #(.ENTRIES(256), .IDX_W(8), .CTR_W(2), .HIST_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_ready(pred_ready),
    .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred)
  );

  bht_gshare #(.ENTRIES(16), .IDX_W(4), .CTR_W(3), .HIST_W(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .pred_valid(sPredValid), .pred_idx(sPredIdx), .pred_ready(sPredReady),
    .pred_resp_valid(sRespValid), .pred_taken(sTaken), .pred_hist(sHist),
    .upd_valid(sUpdValid), .upd_idx(sUpdIdx), .upd_hist(4'h0),
    .upd_taken(sUpdTaken), .upd_mispred(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset;
    for (int i = 0; i < 256; i++) mctr[i] = 1;
    mghr = 0;
    expValid = 0;
    expTaken = 0;
    expHist = 0;
  endtask

  // One cycle in READY: drive inputs, advance the model, compare registered outputs.
  task automatic applyStimulus(input int pv, input int pidx, input int uv, input int uidx,
                               input int uhist, input int ut, input int um);
    int ridx;
    int widx;
    int newGhr;
    pred_valid  = pv[0];
    pred_idx    = pidx[7:0];
    upd_valid   = uv[0];
    upd_idx     = uidx[7:0];
    upd_hist    = uhist[7:0];
    upd_taken   = ut[0];
    upd_mispred = um[0];
    if (rdy) begin
      newGhr = mghr;
      expValid = pv[0];
      if (pv[0]) begin
        ridx = GS ? ((pidx & 255) ^ mghr) : (pidx & 255);
        expTaken = (mctr[ridx] >= 2) ? 1 : 0;
        expHist = GS ? mghr : 0;
        newGhr = ((mghr * 2) + expTaken) % 256;
      end
      if (uv[0]) begin
        widx = GS ? ((uidx ^ uhist) & 255) : (uidx & 255);
        if (ut[0]) mctr[widx] = (mctr[widx] == 3) ? 3 : mctr[widx] + 1;
        else mctr[widx] = (mctr[widx] == 0) ? 0 : mctr[widx] - 1;
        if (um[0] && GS) newGhr = (((uhist & 255) * 2) + ut[0]) % 256;
      end
      mghr = newGhr;
    end
    tick;
    checkOutput("resp_valid", {31'b0, pred_resp_valid}, expValid);
    checkOutput("taken", {31'b0, pred_taken}, expTaken);
    checkOutput("hist", {24'b0, pred_hist}, expHist);
  endtask

  // Walk INIT from reset release, hammering queries/updates that must be ignored.
  task automatic runInit;
    rst_n = 1'b1;
    pred_valid = 1'b1;
    upd_valid = 1'b1;
    upd_mispred = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      pred_idx  = 8'($urandom);
      upd_idx   = 8'($urandom);
      upd_hist  = 8'($urandom);
      upd_taken = 1'($urandom);
      tick;
      checkOutput("init_resp_valid", {31'b0, pred_resp_valid}, 0);
      checkOutput("init_ready", {31'b0, pred_ready}, (i == 256) ? 1 : 0);
    end
    pred_valid = 1'b0;
    upd_valid = 1'b0;
    upd_mispred = 1'b0;
    modelReset();
  endtask

  initial begin
    rdy = 1'b1;
    rst_n = 1'b0;
    pred_valid = 1'b0; pred_idx = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_hist = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
    sPredValid = 1'b0; sPredIdx = '0; sUpdValid = 1'b0; sUpdIdx = '0; sUpdTaken = 1'b0;
    tick;
    checkOutput("rst_ready", {31'b0, pred_ready}, 0);
    checkOutput("rst_resp_valid", {31'b0, pred_resp_valid}, 0);
    checkOutput("rst_taken", {31'b0, pred_taken}, 0);
    checkOutput("rst_hist", {24'b0, pred_hist}, 0);
    runInit();
    checkOutput("small_ready", {31'b0, sPredReady}, 1);

    $display("[TB] saturation on index 5");
    applyStimulus(1, 5, 0, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    checkOutput("t2_init_nt", {31'b0, pred_taken}, 0);
`endif
    repeat (2) applyStimulus(0, 0, 1, 5, 0, 1, 0);
    applyStimulus(1, 5, 0, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    checkOutput("t2_taken", {31'b0, pred_taken}, 1);
`endif
    repeat (5) applyStimulus(0, 0, 1, 5, 0, 1, 0);
    applyStimulus(1, 5, 0, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 1, 5, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 5, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    checkOutput("t2_no_wrap", {31'b0, pred_taken}, 0);
`endif

    $display("[TB] history shift and repair");
    applyStimulus(1, 8'h21, 0, 0, 0, 0, 0);
    applyStimulus(1, 8'h42, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 8'h10, 8'h5A, 1, 1);
    applyStimulus(1, 8'h33, 0, 0, 0, 0, 0);
`ifdef BHT_GSHARE_EN
    checkOutput("t3_repair_hist", {24'b0, pred_hist}, 32'hB5);
`endif

    $display("[TB] same-cycle query and update");
    applyStimulus(1, 9, 1, 9, 0, 1, 0);
`ifndef BHT_GSHARE_EN
    checkOutput("t4_pre_update", {31'b0, pred_taken}, 0);
`endif
    applyStimulus(1, 9, 0, 0, 0, 0, 0);
`ifndef BHT_GSHARE_EN
    checkOutput("t4_post_update", {31'b0, pred_taken}, 1);
`endif
    applyStimulus(1, 3, 1, 7, 8'hC3, 0, 1);
    applyStimulus(1, 4, 0, 0, 0, 0, 0);
`ifdef BHT_GSHARE_EN
    checkOutput("t4_repair_wins", {24'b0, pred_hist}, 32'h86);
`endif

    $display("[TB] freeze with rdy low");
    rdy = 1'b0;
    repeat (3) applyStimulus(1, $urandom, 1, $urandom, $urandom, 1, 1);
    rdy = 1'b1;
    applyStimulus(1, 9, 0, 0, 0, 0, 0);

    $display("[TB] three-bit counter instance");
    sPredValid = 1'b1; sPredIdx = 4'd3;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("small_resp_valid", {31'b0, sRespValid}, 1);
    checkOutput("small_init_nt", {31'b0, sTaken}, 0);
    sPredValid = 1'b0; sUpdValid = 1'b1; sUpdIdx = 4'd3; sUpdTaken = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    sUpdValid = 1'b0; sPredValid = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("small_taken", {31'b0, sTaken}, 1);
    sPredValid = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      rdy = ($urandom_range(0, 7) != 0);
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                    $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    rdy = 1'b1;

    $display("[TB] reset in the middle of INIT");
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    repeat (100) tick;
    rst_n = 1'b0;
    tick;
    checkOutput("mid_rst_ready", {31'b0, pred_ready}, 0);
    checkOutput("mid_rst_resp_valid", {31'b0, pred_resp_valid}, 0);
    runInit();
    applyStimulus(1, 5, 0, 0, 0, 0, 0);
    applyStimulus(1, 9, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
